// File: rtl/rename_stage.sv
// rename_stage: two-wide register rename with a register alias table and a circular
// physical free list; retired pregs come back at the tail, allocations pop the head.
module rename_stage #(
    parameter int AREGS = 32,
    parameter int PREGS = 64,
    parameter int AW    = 5,
    parameter int PW    = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [AW-1:0]    a_rs1_1,
    input  logic [AW-1:0]    a_rs2_1,
    input  logic [AW-1:0]    a_rd_1,
    input  logic [AW-1:0]    a_rs1_2,
    input  logic [AW-1:0]    a_rs2_2,
    input  logic [AW-1:0]    a_rd_2,
    input  logic [31:0]      imm_1,
    input  logic [31:0]      imm_2,
    input  logic [2:0]       alu_op_1,
    input  logic [2:0]       alu_op_2,
    input  logic [6:0]       opcode_1,
    input  logic [6:0]       opcode_2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [PW-1:0]    rs1_1,
    output logic [PW-1:0]    rs2_1,
    output logic [PW-1:0]    rd_1,
    output logic [PW-1:0]    old_rd_1,
    output logic [PW-1:0]    rs1_2,
    output logic [PW-1:0]    rs2_2,
    output logic [PW-1:0]    rd_2,
    output logic [PW-1:0]    old_rd_2,
    output logic [31:0]      imm_o_1,
    output logic [31:0]      imm_o_2,
    output logic [2:0]       alu_op_o_1,
    output logic [2:0]       alu_op_o_2,
    output logic [6:0]       opcode_o_1,
    output logic [6:0]       opcode_o_2,
    input  logic             ret_valid_1,
    input  logic             ret_valid_2,
    input  logic [PW-1:0]    ret_preg_1,
    input  logic [PW-1:0]    ret_preg_2,
    output logic [PREGS-1:0] free_pool,
    output logic [PW:0]      free_count
);

    logic [PW-1:0]    r_rat [AREGS];
    logic [PW-1:0]    r_fl  [PREGS];
    logic [PW-1:0]    r_head, r_tail;
    logic [PW:0]      r_count;
    logic [PREGS-1:0] r_pool;

    logic             w_wr1, w_wr2, w_xfer;
    logic [1:0]       w_need, w_pops;
    logic [PW-1:0]    w_head1, w_tail2, w_p1, w_p2;
    logic [PW-1:0]    w_rs1_1, w_rs2_1, w_rs1_2, w_rs2_2;
    logic [PW-1:0]    w_rd1, w_rd2, w_old1, w_old2;
    logic [PW:0]      w_avail;
    logic             w_req1, w_req2, w_push1, w_push2, w_drop;
    logic [PREGS-1:0] w_pool_nxt;

    function automatic logic f_writes(input logic [6:0] op, input logic [AW-1:0] rd);
        return (op == 7'b0110011 || op == 7'b0010011 || op == 7'b0000011) && (rd != '0);
    endfunction

    assign w_wr1    = f_writes(opcode_1, a_rd_1);
    assign w_wr2    = f_writes(opcode_2, a_rd_2);
    assign w_need   = {1'b0, w_wr1} + {1'b0, w_wr2};
    assign in_ready = (!out_valid || out_ready) && (r_count >= (PW+1)'(w_need));
    assign w_xfer   = in_valid && in_ready;
    assign w_pops   = w_xfer ? w_need : 2'd0;

    // Slot 2 takes the entry after slot 1's only when slot 1 actually allocates.
    assign w_head1  = r_head + PW'(1);
    assign w_p1     = r_fl[r_head];
    assign w_p2     = w_wr1 ? r_fl[w_head1] : r_fl[r_head];

    assign w_rs1_1  = r_rat[a_rs1_1];
    assign w_rs2_1  = r_rat[a_rs2_1];
    assign w_rs1_2  = (w_wr1 && a_rs1_2 == a_rd_1) ? w_p1 : r_rat[a_rs1_2];
    assign w_rs2_2  = (w_wr1 && a_rs2_2 == a_rd_1) ? w_p1 : r_rat[a_rs2_2];
    assign w_rd1    = w_wr1 ? w_p1 : '0;
    assign w_rd2    = w_wr2 ? w_p2 : '0;
    assign w_old1   = w_wr1 ? r_rat[a_rd_1] : '0;
    assign w_old2   = !w_wr2 ? '0 : (w_wr1 && a_rd_2 == a_rd_1) ? w_p1 : r_rat[a_rd_2];

    // Overflow is judged after this cycle's pops; an overflowing push is dropped.
    assign w_req1   = ret_valid_1 && (ret_preg_1 != '0);
    assign w_req2   = ret_valid_2 && (ret_preg_2 != '0);
    assign w_avail  = r_count - (PW+1)'(w_pops);
    assign w_push1  = w_req1 && (w_avail < (PW+1)'(PREGS));
    assign w_push2  = w_req2 && ((w_avail + (PW+1)'(w_push1)) < (PW+1)'(PREGS));
    assign w_drop   = (w_req1 && !w_push1) || (w_req2 && !w_push2);
    assign w_tail2  = r_tail + PW'(w_push1);

    always_comb begin
        w_pool_nxt = r_pool;
        if (w_xfer && w_wr1) w_pool_nxt[w_p1] = 1'b0;
        if (w_xfer && w_wr2) w_pool_nxt[w_p2] = 1'b0;
        if (w_push1)         w_pool_nxt[ret_preg_1] = 1'b1;
        if (w_push2)         w_pool_nxt[ret_preg_2] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < AREGS; i++) r_rat[i] <= PW'(i);
            for (int i = 0; i < PREGS; i++) r_fl[i] <= (i < PREGS-AREGS) ? PW'(AREGS+i) : '0;
            r_head  <= '0;
            r_tail  <= PW'(PREGS-AREGS);
            r_count <= (PW+1)'(PREGS-AREGS);
            r_pool  <= {{(PREGS-AREGS){1'b1}}, {AREGS{1'b0}}};
        end else begin
            // Slot 2 is written last so a shared a_rd ends up on slot 2's preg.
            if (w_xfer && w_wr1) r_rat[a_rd_1] <= w_p1;
            if (w_xfer && w_wr2) r_rat[a_rd_2] <= w_p2;
            if (w_push1) r_fl[r_tail]  <= ret_preg_1;
            if (w_push2) r_fl[w_tail2] <= ret_preg_2;
            r_head  <= r_head + PW'(w_pops);
            r_tail  <= w_tail2 + PW'(w_push2);
            r_count <= w_avail + (PW+1)'(w_push1) + (PW+1)'(w_push2);
            r_pool  <= w_pool_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            rs1_1      <= '0;
            rs2_1      <= '0;
            rd_1       <= '0;
            old_rd_1   <= '0;
            rs1_2      <= '0;
            rs2_2      <= '0;
            rd_2       <= '0;
            old_rd_2   <= '0;
            imm_o_1    <= '0;
            imm_o_2    <= '0;
            alu_op_o_1 <= '0;
            alu_op_o_2 <= '0;
            opcode_o_1 <= '0;
            opcode_o_2 <= '0;
        end else if (w_xfer) begin
            out_valid  <= 1'b1;
            rs1_1      <= w_rs1_1;
            rs2_1      <= w_rs2_1;
            rd_1       <= w_rd1;
            old_rd_1   <= w_old1;
            rs1_2      <= w_rs1_2;
            rs2_2      <= w_rs2_2;
            rd_2       <= w_rd2;
            old_rd_2   <= w_old2;
            imm_o_1    <= imm_1;
            imm_o_2    <= imm_2;
            alu_op_o_1 <= alu_op_1;
            alu_op_o_2 <= alu_op_2;
            opcode_o_1 <= opcode_1;
            opcode_o_2 <= opcode_2;
        end else if (out_ready) begin
            out_valid  <= 1'b0;
        end
    end

    assign free_pool  = r_pool;
    assign free_count = r_count;

    a_no_fl_overflow: assert property (@(posedge clk) disable iff (!rst_n) !w_drop);

endmodule
